abl: RTL

Address Bus Low stage of the 65C02 address path. Each cycle it computes the next low address byte `ADL` from a selected base, a selected offset and a selected carry. It registers `ADL` into `ABL`, maintains `PCL`, and drives the carry-out `CO` that the high-byte stage consumes as its `CI`. A registered copy of the carry lets the microcode add an extra cycle on a page crossing and finish an index fix-up one cycle later.

---
 rtl/abl_if.sv | 27 ++
 rtl/abl.sv | 80 ++++++++
 2 files changed

// File: rtl/abl_if.sv
// Control and result signals of the low address byte stage, grouped for the sequencer
// (master) and the datapath (slave).
interface abl_if;
  logic       ff;
  logic [1:0] vec;
  logic [7:0] DB;
  logic [7:0] REG;
  logic [3:0] op;
  logic [1:0] ci_sel;
  logic       ld_pc;
  logic       inc_pc;
  logic [7:0] ADL;
  logic       CO;
  logic       CC;
  logic [7:0] PCL;
  logic       pc_co;

  modport master (
    output ff, vec, DB, REG, op, ci_sel, ld_pc, inc_pc,
    input  ADL, CO, CC, PCL, pc_co
  );

  modport slave (
    input  ff, vec, DB, REG, op, ci_sel, ld_pc, inc_pc,
    output ADL, CO, CC, PCL, pc_co
  );
endinterface

// File: rtl/abl.sv
// Address Bus Low stage: base + offset + carry adder producing ADL/CO, with the registered
// ABL, page-cross carry CC and program counter low byte PCL.
module abl #(
  parameter logic [7:0] RESET_ABL = 8'hFC
) (
  input logic  clk,
  input logic  rst_n,
  abl_if.slave bus
);

  logic [7:0] r_abl;
  logic [7:0] r_pcl;
  logic       r_cc;

  logic [7:0] w_base;
  logic [7:0] w_off;
  logic       w_ci;
  logic [8:0] w_sum;
  logic [7:0] w_adl;
  logic       w_co;

  always_comb begin
    w_base = 8'h00;
    unique case (bus.op[3:2])
      2'b00: w_base = 8'h00;
      2'b01: w_base = r_abl;
      2'b10: w_base = r_pcl;
      2'b11: w_base = bus.DB;
    endcase

    w_off = 8'h00;
    unique case (bus.op[1:0])
      2'b00: w_off = 8'h00;
      2'b01: w_off = bus.REG;
      2'b10: w_off = 8'hFF;
      2'b11: w_off = bus.DB;
    endcase

    // ci_sel 11 is reserved and behaves like 00
    w_ci = 1'b0;
    unique case (bus.ci_sel)
      2'b00: w_ci = 1'b0;
      2'b01: w_ci = 1'b1;
      2'b10: w_ci = r_cc;
      2'b11: w_ci = 1'b0;
    endcase

    w_sum = {1'b0, w_base} + {1'b0, w_off} + {8'h00, w_ci};

    // Vector mode overrides the adder and suppresses the carry
    if (bus.ff) begin
      w_adl = {5'b11111, bus.vec, 1'b0};
      w_co  = 1'b0;
    end else begin
      w_adl = w_sum[7:0];
      w_co  = w_sum[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abl <= RESET_ABL;
      r_cc  <= 1'b0;
      r_pcl <= 8'h00;
    end else begin
      r_abl <= w_adl;
      r_cc  <= w_co;
      if (bus.ld_pc) begin
        r_pcl <= r_abl + {7'b0000000, bus.inc_pc};
      end
    end
  end

  assign bus.ADL   = w_adl;
  assign bus.CO    = w_co;
  assign bus.CC    = r_cc;
  assign bus.PCL   = r_pcl;
  assign bus.pc_co = bus.ld_pc & bus.inc_pc & (r_abl == 8'hFF);

endmodule
